// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port of the load/store unit.
// master = execute stage plus memory model, slave = load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mwr;
  logic        moe;
  logic [31:0] ma;
  logic [31:0] mwd;
  logic [31:0] mrd;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, mrd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mwr, moe, ma, mwd
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, mrd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mwr, moe, ma, mwd
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, read-modify-write for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
//
// state | meaning
// IDLE  | ready for a request, memory port quiet
// READ  | moe high, memory word captured at end of cycle
// WRITE | mwr high, merged or full word driven on mwd
// RESP  | response held until rsp_ready
module load_store_unit #(
  parameter int MEM_WORDS = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rword_q, rword_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misalign;
  logic        req_err;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [31:0] res;
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{sgn & b[7]}}, b};
      2'b01:   res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    res[7:0]   = wd[7:0];
          2'd1:    res[15:8]  = wd[7:0];
          2'd2:    res[23:16] = wd[7:0];
          default: res[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) res[31:16] = wd[15:0];
        else         res[15:0]  = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  assign req_err = (bus.req_size == 2'b11) || (bus.req_addr[31:2] >= MEM_LIMIT) || misalign;
  assign accept  = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rword_d  = rword_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = bus.req_we;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rdata_d  = 32'h0;
          err_d    = req_err;
          if (req_err)                                  state_d = RESP;
          else if (!bus.req_we || bus.req_size != 2'b10) state_d = READ;
          else                                          state_d = WRITE;
        end
      end
      READ: begin
        rword_d = bus.mrd;
        if (we_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = lane_extract(bus.mrd, size_q, addr_q[1:0], signed_q);
          state_d = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rword_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rword_q  <= rword_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Handshake outputs drop with reset_n; the memory port follows state only so an
  // in-flight WRITE still commits on the reset edge.
  assign bus.req_ready = reset_n && (state_q == IDLE);
  assign bus.rsp_valid = reset_n && (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign bus.moe = (state_q == READ);
  assign bus.mwr = (state_q == WRITE);
  assign bus.ma  = ((state_q == READ) || (state_q == WRITE)) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mwd = (state_q == WRITE) ? lane_merge(rword_q, wdata_q, size_q, addr_q[1:0]) : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios, then random requests
// checked against a word-array reference model.
module tb_load_store_unit;
  localparam int MEM_WORDS = 10;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [MEM_WORDS] = '{default: 32'h0};
  logic [31:0] ref_mem [MEM_WORDS];
  int          widx;

  assign widx = int'(bus.ma[31:2]);

  always_comb begin
    bus.mrd = 32'h0;
    if (bus.moe && widx < MEM_WORDS) bus.mrd = mem[widx];
  end

  always @(posedge clock) begin
    if (bus.mwr && widx < MEM_WORDS) mem[widx] <= bus.mwd;
  end

  int          lat, nwr, nrd, wr_cyc, rd_cyc;
  logic [31:0] wr_ma, wr_mwd, rd_ma, got_rdata;
  logic        got_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, ".rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk({tag, ".rsp_err"},   32'(bus.rsp_err), 32'h0);
    chk({tag, ".mwr"},       32'(bus.mwr), 32'h0);
    chk({tag, ".moe"},       32'(bus.moe), 32'h0);
    chk({tag, ".ma"},        bus.ma, 32'h0);
    chk({tag, ".mwd"},       bus.mwd, 32'h0);
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    logic e;
    e = (sz == 2'd3) || ((a >> 2) >= 32'(MEM_WORDS));
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd1 && (a % 2) != 0) e = 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input int hold);
    logic        e;
    logic [31:0] old, nw, exp_rd;
    int          idx, sh, exp_lat;
    logic        exp_rd_cycle;

    e      = model_err(sz, a);
    idx    = int'(a >> 2);
    old    = e ? 32'h0 : ref_mem[idx];
    nw     = old;
    exp_rd = 32'h0;
    sh     = (sz == 2'd0) ? int'(a % 4) * 8 : int'((a / 2) % 2) * 16;
    if (!e) begin
      if (we) begin
        if (sz == 2'd2)      nw = wd;
        else if (sz == 2'd0) nw = (old & ~(32'hFF << sh))   | ((wd & 32'hFF) << sh);
        else                 nw = (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        ref_mem[idx] = nw;
      end else if (sz == 2'd2) begin
        exp_rd = old;
      end else if (sz == 2'd0) begin
        exp_rd = (old >> sh) & 32'hFF;
        if (sg && exp_rd >= 32'h80) exp_rd = exp_rd | 32'hFFFFFF00;
      end else begin
        exp_rd = (old >> sh) & 32'hFFFF;
        if (sg && exp_rd >= 32'h8000) exp_rd = exp_rd | 32'hFFFF0000;
      end
    end
    exp_lat      = e ? 1 : (we && sz != 2'd2) ? 3 : 2;
    exp_rd_cycle = !e && (!we || sz != 2'd2);

    @(negedge clock);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'h1);
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    bus.rsp_ready  = 1'b0;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_size  = 2'($urandom_range(0, 3));

    lat = 0; nwr = 0; nrd = 0; wr_cyc = 0; rd_cyc = 0;
    wr_ma = 0; wr_mwd = 0; rd_ma = 0; got_rdata = 0; got_err = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clock);
      if (bus.mwr) begin nwr++; wr_cyc = c; wr_ma = bus.ma; wr_mwd = bus.mwd; end
      if (bus.moe) begin nrd++; rd_cyc = c; rd_ma = bus.ma; end
      if (bus.rsp_valid) begin lat = c; got_rdata = bus.rsp_rdata; got_err = bus.rsp_err; end
    end

    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"},   got_rdata, exp_rd);
    chk({tag, ".err"},     32'(got_err), 32'(e));
    chk({tag, ".n_mwr"},   32'(nwr), (we && !e) ? 32'h1 : 32'h0);
    chk({tag, ".n_moe"},   32'(nrd), exp_rd_cycle ? 32'h1 : 32'h0);
    if (we && !e) begin
      chk({tag, ".wr_cycle"}, 32'(wr_cyc), 32'(exp_lat - 1));
      chk({tag, ".wr_ma"},    wr_ma, a & ~32'h3);
      chk({tag, ".mwd"},      wr_mwd, nw);
    end
    if (exp_rd_cycle) begin
      chk({tag, ".rd_cycle"}, 32'(rd_cyc), 32'h1);
      chk({tag, ".rd_ma"},    rd_ma, a & ~32'h3);
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'h1);
      chk({tag, ".hold_rdata"}, bus.rsp_rdata, exp_rd);
      chk({tag, ".hold_err"},   32'(bus.rsp_err), 32'(e));
      chk({tag, ".hold_ready"}, 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clock);
    chk({tag, ".done_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, ".done_ready"}, 32'(bus.req_ready), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // word store then signed word load
    run_req("st_w8", 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 0);
    chk("st_w8.ma_lit", wr_ma, 32'h8);
    run_req("ld_w8", 1'b0, 2'd2, 1'b1, 32'h8, 32'h0, 0);
    chk("ld_w8.lit", got_rdata, 32'hDEADBEEF);

    // byte read-modify-write
    run_req("pre_w4", 1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344, 0);
    run_req("st_b5", 1'b1, 2'd0, 1'b0, 32'h5, 32'h000000AA, 0);
    chk("st_b5.mwd_lit", wr_mwd, 32'h1122AA44);
    chk("st_b5.wr_cyc_lit", 32'(wr_cyc), 32'h2);
    run_req("ld_w4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0);
    chk("ld_w4.lit", got_rdata, 32'h1122AA44);

    // lane extraction and extension
    run_req("pre_w0", 1'b1, 2'd2, 1'b0, 32'h0, 32'h80FF7F01, 0);
    run_req("ld_sb2", 1'b0, 2'd0, 1'b1, 32'h2, 32'h0, 0);
    chk("ld_sb2.lit", got_rdata, 32'hFFFFFFFF);
    run_req("ld_ub2", 1'b0, 2'd0, 1'b0, 32'h2, 32'h0, 0);
    chk("ld_ub2.lit", got_rdata, 32'h000000FF);
    run_req("ld_sh2", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 0);
    chk("ld_sh2.lit", got_rdata, 32'hFFFF80FF);
    run_req("ld_uh0", 1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 0);
    chk("ld_uh0.lit", got_rdata, 32'h00007F01);

    // errors
    run_req("err_oob", 1'b1, 2'd2, 1'b0, 32'h28, 32'h55AA55AA, 0);
    chk("err_oob.err_lit", 32'(got_err), 32'h1);
    chk("err_oob.lat_lit", 32'(lat), 32'h1);
    run_req("err_sz3", 1'b0, 2'd3, 1'b0, 32'h4, 32'h0, 0);
    chk("err_sz3.err_lit", 32'(got_err), 32'h1);
    run_req("ld_h1", 1'b0, 2'd1, 1'b0, 32'h1, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("ld_h1.err_lit", 32'(got_err), 32'h1);
`else
    chk("ld_h1.rdata_lit", got_rdata, 32'h00007F01);
`endif

    // response held by consumer back-pressure
    run_req("ld_hold", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 5);

    // reset asserted during the WRITE cycle of a word store
    @(negedge clock);
    bus.req_we     = 1'b1;
    bus.req_size   = 2'd2;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'hC;
    bus.req_wdata  = 32'h12345678;
    bus.req_valid  = 1'b1;
    bus.rsp_ready  = 1'b1;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clock);
    chk("rstwr.mwr", 32'(bus.mwr), 32'h1);
    reset_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) seen++;
      chk_reset_outputs($sformatf("rstwr.held%0d", i));
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) seen++;
    end
    chk("rstwr.no_rsp", 32'(seen), 32'h0);
    bus.rsp_ready = 1'b0;
    ref_mem[3] = 32'h12345678;
    run_req("rstwr.ld", 1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 0);
    chk("rstwr.ld_lit", got_rdata, 32'h12345678);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 32'($urandom_range(0, 4 * MEM_WORDS + 7)),
              $urandom, int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < MEM_WORDS; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the data memory block. Accepts one load or store request at a time over a valid/ready handshake and drives the memory's `mwr`/`moe`/`ma`/`mwd` port. Sub-word stores are done as read-modify-write, because the memory only writes whole words. Load data is lane-extracted and sign- or zero-extended, and each request returns exactly one response.

## Interface
- `MEM_WORDS`, default 10: number of 32-bit words backed by data memory. Any word index `>= MEM_WORDS` is an access error.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: loads sign-extend when 1, zero-extend when 0. Ignored for words and stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: load result. 0 for stores and errors.
- `rsp_err` out 1: request was rejected; no memory write occurred.
- `mwr` out 1: memory write enable.
- `moe` out 1: memory output enable.
- `ma` out 32: word-aligned memory byte address, {addr[31:2], 2'b00}.
- `mwd` out 32: memory write data.
- `mrd` in 32: memory read data, combinational from `ma`/`moe`.

## Operation
- FSM states and memory-port behaviour:
  - IDLE: `req_ready`=1; `mwr`=0, `moe`=0, `ma`=0, `mwd`=0.
  - READ: `moe`=1, `ma` driven; `mrd` is captured at the end of the cycle.
  - WRITE: `mwr`=1, `ma` and `mwd` driven.
  - RESP: `rsp_valid`=1.
- On `req_valid && req_ready`, all `req_*` fields are captured. Memory port signals are decoded from state and captured registers only; there is no combinational path from `req_*` to the memory port.
- Transitions out of IDLE:
  - Error → RESP with `rsp_err`=1.
  - Load → READ → RESP.
  - Word store → WRITE → RESP.
  - Byte/half store → READ → WRITE → RESP.
- RESP holds `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready`=1, then returns to IDLE. No new request is accepted in the same cycle.
- Error conditions: `req_size`=11; `req_addr[31:2] >= MEM_WORDS`; misalignment (see Configuration). An errored request never asserts `mwr` or `moe`.
- Lanes are little-endian.
  - Byte lane = addr[1:0], lane 0 = bits [7:0].
  - Half lane = addr[1]: 0 selects [15:0], 1 selects [31:16].
- Load extract: shift the selected lane down to bit 0, then extend per `req_signed`.
- Store merge: `mwd` = word captured in READ with the selected lane replaced by the low bits of `req_wdata`. Word stores drive `req_wdata` unmodified.

## Timing
- Cycle 0 is the accept edge.
  - Error: `rsp_valid` from cycle 1.
  - Load: READ in cycle 1, `rsp_valid` from cycle 2.
  - Word store: WRITE in cycle 1 (memory commits at end of cycle 1), `rsp_valid` from cycle 2.
  - Sub-word store: READ cycle 1, WRITE cycle 2, `rsp_valid` from cycle 3.
- Best-case throughput, with `rsp_ready` held at 1:
  - Loads and word stores: one request every 3 cycles.
  - Sub-word stores: one request every 4 cycles.
- Reset values (held while `reset_n`=0):
  - `req_ready`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `mwr`=0, `moe`=0, `ma`=0, `mwd`=0.
  - FSM → IDLE.
- Reset mid-operation:
  - `reset_n` low during a WRITE cycle: that write still commits at the edge, because `mwr` was high for the cycle. No response is produced.
  - Reset during READ or RESP discards the request and its response.
- `req_valid` deasserted while `req_ready`=0 is legal and ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Half access with addr[0]=1 → error.
  - Word access with addr[1:0]≠0 → error.
- `LSU_MISALIGN_TRAP_EN` undefined: low address bits are silently forced to alignment, and no error is raised.
  - Half access ignores addr[0].
  - Word access ignores addr[1:0].

## Test plan
- Word store 0xDEADBEEF @0x8, then signed word load @0x8:
  - Store: `mwr` high exactly 1 cycle, `ma`=0x8; `rsp_valid` at cycle 2 with `rsp_err`=0.
  - Load: `rsp_rdata`=0xDEADBEEF at cycle 2.
- Preload word 0x11223344 @0x4. Byte store 0xAA @0x5, then unsigned word load @0x4:
  - READ at cycle 1, WRITE at cycle 2 with `mwd`=0x1122AA44.
  - Load returns 0x1122AA44.
- Memory word 0x80FF7F01 @0x0:
  - Signed byte @0x2 → 0xFFFFFFFF; unsigned byte @0x2 → 0x000000FF.
  - Signed half @0x2 → 0xFFFF80FF; unsigned half @0x0 → 0x00007F01.
- Error cases:
  - Word store @0x28 with `MEM_WORDS`=10 → `rsp_err`=1 at cycle 1; `mwr`/`moe` never assert.
  - `req_size`=11 → `rsp_err`=1.
  - Half load @0x1 → `rsp_err`=1 with `LSU_MISALIGN_TRAP_EN` defined; returns the half @0x0 without it.
- Hold `rsp_ready`=0 for 5 cycles after a load: `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable and `req_ready` stays 0; IDLE is reached the cycle after `rsp_ready`=1.
- Drop `reset_n` during the WRITE cycle of a word store of 0x12345678 @0xC:
  - Memory @0xC reads back 0x12345678 after reset.
  - No `rsp_valid` is observed.
  - All outputs hold their reset values while `reset_n`=0.
